rd_serial_emulator: RTL



---
 rtl/rd_emu_pkg.sv | 24 ++
 rtl/rd_emu_word_gen.sv | 22 ++
 rtl/rd_serial_emulator.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/rd_emu_pkg.sv
// Shared types and constants for the RD front-end emulator.
// The parity-injection build option is RD_EMU_PARITY_INJ_EN.
package rd_emu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DELAY = 3'd1,
        ST_LEAD  = 3'd2,
        ST_DATA  = 3'd3,
        ST_TRAIL = 3'd4,
        ST_DONE  = 3'd5
    } rd_emu_state_e;

    localparam int RD_BITS_PER_WORD = 13;
    localparam int RD_DATA_BITS     = 12;
    localparam int RD_WORDS         = 2048;
    localparam int RD_WORD_CNT_W    = $clog2(RD_WORDS);
    localparam int RD_BIT_CNT_W     = $clog2(RD_BITS_PER_WORD);

    function automatic logic odd_parity(input logic [RD_DATA_BITS-1:0] w);
        return ~^w;
    endfunction

endpackage

// File: rtl/rd_emu_word_gen.sv
// Combinational word pattern: lane 0 is seed+index, lane 1 its complement,
// followed by an odd-parity bit that the inject flag inverts.
module rd_emu_word_gen
    import rd_emu_pkg::*;
(
    input  logic [RD_DATA_BITS-1:0]     seed,
    input  logic [RD_WORD_CNT_W-1:0]    word_idx,
    input  logic                        lane,
    input  logic                        inject,
    output logic [RD_BITS_PER_WORD-1:0] word
);

    logic [RD_DATA_BITS-1:0] base;
    logic [RD_DATA_BITS-1:0] data;

    always_comb begin
        base = seed + RD_DATA_BITS'(word_idx);
        data = lane ? ~base : base;
        word = {data, odd_parity(data) ^ inject};
    end

endmodule

// File: rtl/rd_serial_emulator.sv
// RD front-end emulator: trigger, programmable delay, then a gated serial clock
// with two 13-bit-word data lanes. Parity injection is built with RD_EMU_PARITY_INJ_EN.
module rd_serial_emulator
    import rd_emu_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int TRIG_DELAY = 240,
    parameter int LEAD_CLKS  = 1,
    parameter int TRAIL_CLKS = 11
) (
    input  logic                     CLK120,
    input  logic                     RST_N,
    input  logic                     ENABLE,
    input  logic                     TRIG_IN,
    input  logic [RD_DATA_BITS-1:0]  SEED,
    output logic                     SERIAL_CLK_OUT,
    output logic                     SERIAL_DATA0_OUT,
    output logic                     SERIAL_DATA1_OUT,
    output logic                     BUSY,
    output logic                     XFR_DONE,
    output logic [7:0]               DROP_COUNT
`ifdef RD_EMU_PARITY_INJ_EN
    ,
    input  logic [1:0]               PAR_ERR_INJ,
    input  logic [RD_WORD_CNT_W-1:0] ERR_WORD
`endif
);

    localparam int DIV_W   = $clog2(CLK_DIV);
    localparam int DLY_W   = (TRIG_DELAY > 1) ? $clog2(TRIG_DELAY) : 1;
    localparam int PER_MAX = (LEAD_CLKS > TRAIL_CLKS) ? LEAD_CLKS : TRAIL_CLKS;
    localparam int PER_W   = (PER_MAX > 1) ? $clog2(PER_MAX) : 1;

    localparam logic [DIV_W-1:0]        DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]        DIV_HALF   = DIV_W'(CLK_DIV / 2);
    localparam logic [PER_W-1:0]        LEAD_LAST  = PER_W'(LEAD_CLKS - 1);
    localparam logic [PER_W-1:0]        TRAIL_LAST = PER_W'(TRAIL_CLKS - 1);
    localparam logic [RD_BIT_CNT_W-1:0] BIT_LAST   = RD_BIT_CNT_W'(RD_BITS_PER_WORD - 1);
    localparam rd_emu_state_e AFTER_DELAY = (LEAD_CLKS == 0) ? ST_DATA : ST_LEAD;
    localparam rd_emu_state_e AFTER_DATA  = (TRAIL_CLKS == 0) ? ST_DONE : ST_TRAIL;

    rd_emu_state_e state_q, state_d;
    logic                      trig_q;
    logic [DLY_W-1:0]          dly_q, dly_d;
    logic [DIV_W-1:0]          div_q, div_d;
    logic [PER_W-1:0]          per_q, per_d;
    logic [RD_WORD_CNT_W-1:0]  word_q, word_d;
    logic [RD_BIT_CNT_W-1:0]   bit_q, bit_d;
    logic [RD_DATA_BITS-1:0]   seed_q, seed_d;
    logic [7:0]                drop_d;
    logic                      trig_rise, accept, period_end;
    logic                      sclk_d, data0_d, data1_d, busy_d, done_d;
    logic [RD_BIT_CNT_W-1:0]   bit_sel;
    logic [RD_BITS_PER_WORD-1:0] word0, word1;
    logic [1:0]                inj_hit;

    always_comb begin
        trig_rise  = TRIG_IN & ~trig_q;
        accept     = trig_rise & ENABLE & (state_q == ST_IDLE);
        period_end = (div_q == DIV_LAST);

        state_d = state_q;
        dly_d   = dly_q;
        div_d   = div_q;
        per_d   = per_q;
        word_d  = word_q;
        bit_d   = bit_q;
        seed_d  = seed_q;
        drop_d  = DROP_COUNT;

        if (trig_rise && state_q != ST_IDLE && DROP_COUNT != 8'hFF)
            drop_d = DROP_COUNT + 8'd1;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_DELAY;
                    dly_d   = DLY_W'(TRIG_DELAY - 1);
                    seed_d  = SEED;
                end
            end
            ST_DELAY: begin
                if (dly_q == '0) begin
                    state_d = AFTER_DELAY;
                    div_d   = '0;
                    per_d   = '0;
                end else begin
                    dly_d = dly_q - 1'b1;
                end
            end
            ST_LEAD: begin
                div_d = period_end ? '0 : div_q + 1'b1;
                if (period_end) begin
                    if (per_q == LEAD_LAST) begin
                        per_d   = '0;
                        state_d = ST_DATA;
                    end else begin
                        per_d = per_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                div_d = period_end ? '0 : div_q + 1'b1;
                if (period_end) begin
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
                        if (word_q == '1) begin
                            word_d  = '0;
                            state_d = AFTER_DATA;
                        end else begin
                            word_d = word_q + 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ST_TRAIL: begin
                div_d = period_end ? '0 : div_q + 1'b1;
                if (period_end && per_q == TRAIL_LAST) begin
                    per_d   = '0;
                    state_d = ST_DONE;
                end else if (period_end) begin
                    per_d = per_q + 1'b1;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

`ifdef RD_EMU_PARITY_INJ_EN
    logic [1:0]               inj_q;
    logic [RD_WORD_CNT_W-1:0] err_word_q;

    always_ff @(posedge CLK120) begin
        if (!RST_N) begin
            inj_q      <= '0;
            err_word_q <= '0;
        end else if (accept) begin
            inj_q      <= PAR_ERR_INJ;
            err_word_q <= ERR_WORD;
        end
    end

    always_comb inj_hit = inj_q & {2{word_d == err_word_q}};
`else
    always_comb inj_hit = '0;
`endif

    rd_emu_word_gen u_lane0 (
        .seed     (seed_q),
        .word_idx (word_d),
        .lane     (1'b0),
        .inject   (inj_hit[0]),
        .word     (word0)
    );

    rd_emu_word_gen u_lane1 (
        .seed     (seed_q),
        .word_idx (word_d),
        .lane     (1'b1),
        .inject   (inj_hit[1]),
        .word     (word1)
    );

    // Outputs are decoded from next-state values so the registered pins line up
    // with the counters; the bit position only moves at d=0, keeping data stable.
    always_comb begin
        bit_sel = BIT_LAST - bit_d;
        sclk_d  = (state_d inside {ST_LEAD, ST_DATA, ST_TRAIL}) && (div_d >= DIV_HALF);
        data0_d = (state_d == ST_DATA) && word0[bit_sel];
        data1_d = (state_d == ST_DATA) && word1[bit_sel];
        busy_d  = !(state_d inside {ST_IDLE, ST_DONE});
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge CLK120) begin
        if (!RST_N) begin
            state_q          <= ST_IDLE;
            trig_q           <= 1'b0;
            dly_q            <= '0;
            div_q            <= '0;
            per_q            <= '0;
            word_q           <= '0;
            bit_q            <= '0;
            seed_q           <= '0;
            DROP_COUNT       <= '0;
            SERIAL_CLK_OUT   <= 1'b0;
            SERIAL_DATA0_OUT <= 1'b0;
            SERIAL_DATA1_OUT <= 1'b0;
            BUSY             <= 1'b0;
            XFR_DONE         <= 1'b0;
        end else begin
            state_q          <= state_d;
            trig_q           <= TRIG_IN;
            dly_q            <= dly_d;
            div_q            <= div_d;
            per_q            <= per_d;
            word_q           <= word_d;
            bit_q            <= bit_d;
            seed_q           <= seed_d;
            DROP_COUNT       <= drop_d;
            SERIAL_CLK_OUT   <= sclk_d;
            SERIAL_DATA0_OUT <= data0_d;
            SERIAL_DATA1_OUT <= data1_d;
            BUSY             <= busy_d;
            XFR_DONE         <= done_d;
        end
    end

endmodule
